mestre_i2c: RTL and testbench

Single-byte I2C master sequencer that drives scl/sda toward slaves such as dec_i2c.
- Accepts one transaction request (7-bit address, R/W bit, one data byte).
- Generates START, address+R/W, ACK sampling, one data byte, ACK/NACK and STOP.
- Reports completion and NACK status to the requesting logic over a start/pronto handshake.

---
 rtl/i2c_pkg.sv | 26 ++
 rtl/divisor_scl.sv | 35 +++
 rtl/mestre_i2c.sv | 210 +++++++++++++++++++++
 tb/tb_mestre_i2c.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master (mestre_i2c).
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    localparam logic OP_ESCRITA = 1'b0;
    localparam logic OP_LEITURA = 1'b1;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        START    = 3'd1,
        ENDERECO = 3'd2,
        ACK_END  = 3'd3,
        DADO     = 3'd4,
        ACK_DADO = 3'd5,
        STOP     = 3'd6,
        FIM      = 3'd7
    } estado_t;

    // Open-drain style: a 0 bit is sent by pulling the line low.
    function automatic logic sda_puxa(input logic bit_v);
        return ~bit_v;
    endfunction

endpackage

// File: rtl/divisor_scl.sv
// Quarter-period tick generator for the I2C master; the counter only runs while enabled
// and can be frozen at zero (clock stretching) through i_hold.
module divisor_scl #(
    parameter int DIV_QUARTO = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_hold,
    output logic o_tick
);

    localparam int CW = $clog2(DIV_QUARTO);
    localparam logic [CW-1:0] ULTIMO = CW'(DIV_QUARTO - 1);

    logic [CW-1:0] r_cnt;

    // Quarter counter: cleared while idle, parked at zero while held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (!i_enable) begin
            r_cnt <= {CW{1'b0}};
        end else if (i_hold && (r_cnt == {CW{1'b0}})) begin
            r_cnt <= {CW{1'b0}};
        end else if (r_cnt == ULTIMO) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tick = i_enable && (r_cnt == ULTIMO);

endmodule

// File: rtl/mestre_i2c.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Optional clock stretching on scl_in is enabled with the I2C_CLOCK_STRETCH_EN macro.
module mestre_i2c
    import i2c_pkg::*;
#(
    parameter int DIV_QUARTO = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic [I2C_ADDR_W-1:0] endereco,
    input  logic                  operacao,
    input  logic [I2C_BYTE_W-1:0] dado_escrita,
    output logic [I2C_BYTE_W-1:0] dado_lido,
    output logic                  ocupado,
    output logic                  pronto,
    output logic                  nack,
    output logic                  scl,
    output logic                  sda_oe,
    input  logic                  sda_in,
    input  logic                  scl_in
);

    estado_t               r_estado;
    logic [1:0]            r_q;
    logic [2:0]            r_bit;
    logic [I2C_BYTE_W-1:0] r_shift;
    logic [I2C_BYTE_W-1:0] r_dw;
    logic [I2C_BYTE_W-1:0] r_dado_lido;
    logic                  r_op;
    logic                  r_scl;
    logic                  r_sda_oe;
    logic                  r_ocupado;
    logic                  r_pronto;
    logic                  r_nack;
    logic                  w_tick;
    logic                  w_hold;

`ifdef I2C_CLOCK_STRETCH_EN
    // A slave holding scl low freezes the quarter counter at the start of a high quarter.
    assign w_hold = r_scl & ~scl_in;
`else
    logic w_scl_in_unused;
    assign w_scl_in_unused = scl_in;
    assign w_hold          = 1'b0;
`endif

    divisor_scl #(
        .DIV_QUARTO (DIV_QUARTO)
    ) u_divisor (
        .clk      (clk),
        .reset    (reset),
        .i_enable (r_ocupado),
        .i_hold   (w_hold),
        .o_tick   (w_tick)
    );

    // Transaction sequencer; every bus change is made on the tick that ends the current quarter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado    <= OCIOSO;
            r_q         <= 2'd0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_dw        <= 8'h00;
            r_dado_lido <= 8'h00;
            r_op        <= 1'b0;
            r_scl       <= 1'b1;
            r_sda_oe    <= 1'b0;
            r_ocupado   <= 1'b0;
            r_pronto    <= 1'b0;
            r_nack      <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO, FIM: begin
                    r_pronto <= 1'b0;
                    if (inicio) begin
                        r_op      <= operacao;
                        r_dw      <= dado_escrita;
                        r_shift   <= {endereco, operacao};
                        r_nack    <= 1'b0;
                        r_ocupado <= 1'b1;
                        r_estado  <= START;
                        r_q       <= 2'd0;
                        r_bit     <= 3'd0;
                        r_scl     <= 1'b1;
                        r_sda_oe  <= 1'b0;
                    end else begin
                        r_estado <= OCIOSO;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_q == 2'd0) begin
                            r_q      <= 2'd1;
                            r_sda_oe <= 1'b1;
                        end else begin
                            r_estado <= ENDERECO;
                            r_q      <= 2'd0;
                            r_bit    <= 3'd0;
                            r_scl    <= 1'b0;
                            r_sda_oe <= sda_puxa(r_shift[7]);
                        end
                    end
                end
                ENDERECO, ACK_END, DADO, ACK_DADO: begin
                    if (w_tick) begin
                        case (r_q)
                            2'd0: r_q <= 2'd1;
                            2'd1: begin
                                r_q   <= 2'd2;
                                r_scl <= 1'b1;
                            end
                            2'd2: begin
                                r_q <= 2'd3;
                                if (r_estado == DADO && r_op == OP_LEITURA) begin
                                    r_shift <= {r_shift[6:0], sda_in};
                                end else if (r_estado == ACK_END ||
                                             (r_estado == ACK_DADO && r_op == OP_ESCRITA)) begin
                                    r_nack <= r_nack | sda_in;
                                end
                            end
                            default: begin
                                r_q   <= 2'd0;
                                r_scl <= 1'b0;
                                case (r_estado)
                                    ENDERECO: begin
                                        if (r_bit == 3'd7) begin
                                            r_estado <= ACK_END;
                                            r_sda_oe <= 1'b0;
                                        end else begin
                                            r_bit    <= r_bit + 3'd1;
                                            r_shift  <= {r_shift[6:0], 1'b0};
                                            r_sda_oe <= sda_puxa(r_shift[6]);
                                        end
                                    end
                                    ACK_END: begin
                                        if (r_nack) begin
                                            r_estado <= STOP;
                                            r_sda_oe <= 1'b1;
                                        end else begin
                                            r_estado <= DADO;
                                            r_bit    <= 3'd0;
                                            if (r_op == OP_LEITURA) begin
                                                r_shift  <= 8'h00;
                                                r_sda_oe <= 1'b0;
                                            end else begin
                                                r_shift  <= r_dw;
                                                r_sda_oe <= sda_puxa(r_dw[7]);
                                            end
                                        end
                                    end
                                    DADO: begin
                                        if (r_bit == 3'd7) begin
                                            r_estado <= ACK_DADO;
                                            r_sda_oe <= 1'b0;
                                        end else if (r_op == OP_LEITURA) begin
                                            r_bit    <= r_bit + 3'd1;
                                            r_sda_oe <= 1'b0;
                                        end else begin
                                            r_bit    <= r_bit + 3'd1;
                                            r_shift  <= {r_shift[6:0], 1'b0};
                                            r_sda_oe <= sda_puxa(r_shift[6]);
                                        end
                                    end
                                    default: begin
                                        r_estado <= STOP;
                                        r_sda_oe <= 1'b1;
                                        if (r_op == OP_LEITURA) begin
                                            r_dado_lido <= r_shift;
                                        end
                                    end
                                endcase
                            end
                        endcase
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        case (r_q)
                            2'd0: begin
                                r_q   <= 2'd1;
                                r_scl <= 1'b1;
                            end
                            2'd1: begin
                                r_q      <= 2'd2;
                                r_sda_oe <= 1'b0;
                            end
                            default: begin
                                r_q       <= 2'd0;
                                r_estado  <= FIM;
                                r_ocupado <= 1'b0;
                                r_pronto  <= 1'b1;
                            end
                        endcase
                    end
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    assign dado_lido = r_dado_lido;
    assign ocupado   = r_ocupado;
    assign pronto    = r_pronto;
    assign nack      = r_nack;
    assign scl       = r_scl;
    assign sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_mestre_i2c.sv
// Self-checking bench for mestre_i2c: behavioural slave + bus monitor, randomized transactions.
module tb_mestre_i2c;

    localparam int DIV = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       inicio = 1'b0;
    logic [6:0] endereco = 7'h00;
    logic       operacao = 1'b0;
    logic [7:0] dado_escrita = 8'h00;
    logic [7:0] dado_lido;
    logic       ocupado, pronto, nack, scl, sda_oe, sda_in, scl_in;

    logic slave_pull = 1'b0;
    logic stretch_low = 1'b0;

    assign sda_in = ~(sda_oe | slave_pull);
    assign scl_in = scl & ~stretch_low;

    always #5 clk = ~clk;

    mestre_i2c #(.DIV_QUARTO(DIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .inicio       (inicio),
        .endereco     (endereco),
        .operacao     (operacao),
        .dado_escrita (dado_escrita),
        .dado_lido    (dado_lido),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .nack         (nack),
        .scl          (scl),
        .sda_oe       (sda_oe),
        .sda_in       (sda_in),
        .scl_in       (scl_in)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model of the current transaction
    logic [6:0] m_addr;
    logic       m_op;
    logic [7:0] m_wd, m_rd;
    logic       s_ack_a = 1'b0, s_ack_d = 1'b0, s_op = 1'b0;
    logic [7:0] s_rdata = 8'h00;
    logic       exp_nack;
    int         exp_q;
    logic [7:0] exp_lido = 8'h00;

    // Bus monitor state
    logic obs [0:31];
    int   obs_n = 0;
    int   fall_k = 0;
    logic p_scl = 1'b1, p_sda = 1'b1;

    // Slave decision for the bit slot that begins at scl falling edge number k after START
    function automatic logic slave_drive(input int k);
        if (k == 8) return s_ack_a;
        if (s_ack_a && s_op && k >= 9 && k <= 16) return !s_rdata[16-k];
        if (s_ack_a && !s_op && k == 17) return s_ack_d;
        return 1'b0;
    endfunction

    // Behavioural slave and bit monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            slave_pull <= 1'b0;
            fall_k     <= 0;
            p_scl      <= 1'b1;
            p_sda      <= 1'b1;
        end else begin
            p_scl <= scl;
            p_sda <= sda_in;
            if (p_scl && scl && p_sda && !sda_in) begin
                obs_n      <= 0;
                fall_k     <= 0;
                slave_pull <= 1'b0;
            end else if (!p_scl && scl) begin
                if (obs_n < 32) obs[obs_n] <= sda_in;
                obs_n <= obs_n + 1;
            end else if (p_scl && !scl) begin
                slave_pull <= slave_drive(fall_k);
                fall_k     <= fall_k + 1;
            end
        end
    end

    // Called at a negedge: present a request; the next posedge accepts it
    task automatic issue(input logic [6:0] a, input logic op, input logic [7:0] wd,
                         input logic [7:0] rd, input logic aa, input logic ad);
        m_addr = a; m_op = op; m_wd = wd; m_rd = rd;
        s_ack_a = aa; s_ack_d = ad; s_op = op; s_rdata = rd;
        endereco = a; operacao = op; dado_escrita = wd; inicio = 1'b1;
        exp_nack = !aa || (!op && !ad);
        exp_q    = aa ? 77 : 41;
        if (aa && op) exp_lido = rd;
    endtask

    task automatic finish_txn(input logic chain, input logic poke, input int extra);
        int   t0;
        logic got;
        logic [7:0] b;
        @(negedge clk);
        inicio = 1'b0;
        t0 = cyc;
        check("aceite_ocupado", {31'd0, ocupado}, 32'd1);
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (poke && i == 40) begin
                inicio = 1'b1;
                endereco = ~m_addr;
            end else if (poke && i == 41) begin
                inicio = 1'b0;
            end
            if (pronto) got = 1'b1;
        end
        check("pronto_visto", {31'd0, got}, 32'd1);
        check("latencia", cyc - t0, exp_q * DIV + extra);
        check("nack", {31'd0, nack}, {31'd0, exp_nack});
        check("ocupado_fim", {31'd0, ocupado}, 32'd0);
        check("scl_fim", {31'd0, scl}, 32'd1);
        check("sda_oe_fim", {31'd0, sda_oe}, 32'd0);
        check("dado_lido", {24'd0, dado_lido}, {24'd0, exp_lido});
        check("n_bits", obs_n, s_ack_a ? 19 : 10);
        b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], obs[i]};
        check("byte_end", {24'd0, b}, {24'd0, m_addr, m_op});
        check("ack_end", {31'd0, obs[8]}, {31'd0, !s_ack_a});
        if (s_ack_a) begin
            b = 8'h00;
            for (int i = 9; i < 17; i++) b = {b[6:0], obs[i]};
            check("byte_dado", {24'd0, b}, {24'd0, (m_op ? m_rd : m_wd)});
            check("ack_dado", {31'd0, obs[17]}, {31'd0, (m_op ? 1'b1 : !s_ack_d)});
        end
        if (!chain) begin
            @(negedge clk);
            check("pronto_pulso", {31'd0, pronto}, 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_pronto", {31'd0, pronto}, 32'd0);
        check("rst_nack", {31'd0, nack}, 32'd0);
        check("rst_dado_lido", {24'd0, dado_lido}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Write with ACKs, chained straight into a read issued during the pronto cycle
        issue(7'b1001000, 1'b0, 8'hA5, 8'h00, 1'b1, 1'b1);
        finish_txn(1'b1, 1'b0, 0);
        issue(7'h21, 1'b1, 8'h00, 8'h5A, 1'b1, 1'b0);
        finish_txn(1'b0, 1'b1, 0);

        // Address NACK
        @(negedge clk);
        issue(7'h3C, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1);
        finish_txn(1'b0, 1'b0, 0);

        // Randomized transactions
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            issue(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            finish_txn(1'($urandom_range(0, 1)), 1'b0, 0);
        end

`ifdef I2C_CLOCK_STRETCH_EN
        @(negedge clk);
        issue(7'h55, 1'b0, 8'h3C, 8'h00, 1'b1, 1'b1);
        fork
            finish_txn(1'b0, 1'b0, 10);
            begin : estica
                logic achou;
                achou = 1'b0;
                for (int i = 0; i < 4000 && !achou; i++) begin
                    @(negedge clk);
                    if (obs_n == 3 && scl == 1'b0) achou = 1'b1;
                end
                check("estica_sinc", {31'd0, achou}, 32'd1);
                stretch_low = 1'b1;
                achou = 1'b0;
                for (int i = 0; i < 100 && !achou; i++) begin
                    @(negedge clk);
                    if (scl) achou = 1'b1;
                end
                repeat (10) @(negedge clk);
                stretch_low = 1'b0;
            end
        join
`endif

        // Reset in the middle of the address phase
        @(negedge clk);
        issue(7'h4D, 1'b0, 8'h99, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        inicio = 1'b0;
        repeat (15 * DIV) @(negedge clk);
        check("meio_ocupado", {31'd0, ocupado}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_meio_scl", {31'd0, scl}, 32'd1);
        check("rst_meio_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_meio_ocupado", {31'd0, ocupado}, 32'd0);
        check("rst_meio_pronto", {31'd0, pronto}, 32'd0);
        exp_lido = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Recovery after the abort
        issue(7'h12, 1'b1, 8'h00, 8'hC3, 1'b1, 1'b0);
        finish_txn(1'b0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
